// File: rtl/miriscv_lsu_ctrl.sv
// Load/store sequencing controller: grant/response data-bus handshake, core stall, load alignment.
// Optional MIRISCV_LSU_MISALIGN_TRAP_EN: misaligned H/HU/W accesses skip the bus and report an error.
module miriscv_lsu_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [2:0]        lsu_size_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [31:0]       lsu_data_i,
   output logic [31:0]       lsu_data_o,
   output logic              lsu_stall_req_o,
   output logic              lsu_err_o,
   output logic              data_req_o,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [31:0]       data_wdata_o,
   input  logic              data_gnt_i,
   input  logic              data_rvalid_i,
   input  logic [31:0]       data_rdata_i
);

   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RVALID,
      DONE
   } stateT;

   stateT            state, stateNext;
   logic             weQ;
   logic [2:0]       sizeQ;
   logic [1:0]       offQ;
   logic [CNT_W-1:0] tmoCnt;
   logic             inWait;
   logic             tmoHit;
   logic             misalign;
   logic [3:0]       beNext;
   logic [31:0]      wdataNext;
   logic [7:0]       rByte;
   logic [15:0]      rHalf;
   logic [31:0]      loadData;

   assign inWait          = (state == WAIT_GNT) || (state == WAIT_RVALID);
   assign tmoHit          = (TIMEOUT != 0) && inWait && (tmoCnt == CNT_W'(TIMEOUT));
   assign lsu_stall_req_o = lsu_req_i && (state != DONE);

`ifdef MIRISCV_LSU_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      case (lsu_size_i)
         LDST_H, LDST_HU: misalign = lsu_addr_i[0];
         LDST_W:          misalign = |lsu_addr_i[1:0];
         default:         misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      beNext    = 4'b1111;
      wdataNext = lsu_data_i;
      case (lsu_size_i)
         LDST_B, LDST_BU: begin
            beNext    = 4'b0001 << lsu_addr_i[1:0];
            wdataNext = {4{lsu_data_i[7:0]}};
         end
         LDST_H, LDST_HU: begin
            beNext    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
            wdataNext = {2{lsu_data_i[15:0]}};
         end
         default: begin
            beNext    = 4'b1111;
            wdataNext = lsu_data_i;
         end
      endcase
   end

   always_comb begin
      rByte = data_rdata_i[7:0];
      case (offQ)
         2'd0: rByte = data_rdata_i[7:0];
         2'd1: rByte = data_rdata_i[15:8];
         2'd2: rByte = data_rdata_i[23:16];
         2'd3: rByte = data_rdata_i[31:24];
         default: rByte = data_rdata_i[7:0];
      endcase
      rHalf    = offQ[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
      loadData = data_rdata_i;
      case (sizeQ)
         LDST_B:  loadData = {{24{rByte[7]}}, rByte};
         LDST_BU: loadData = {24'b0, rByte};
         LDST_H:  loadData = {{16{rHalf[15]}}, rHalf};
         LDST_HU: loadData = {16'b0, rHalf};
         default: loadData = data_rdata_i;
      endcase
   end

   // data_req_o is decoded from state so an asynchronous reset drops it at once
   always_comb begin
      stateNext  = state;
      data_req_o = 1'b0;
      case (state)
         IDLE: begin
            if (lsu_req_i) stateNext = misalign ? DONE : WAIT_GNT;
         end
         WAIT_GNT: begin
            if (tmoHit) begin
               stateNext = DONE;
            end else begin
               data_req_o = 1'b1;
               if (data_gnt_i) stateNext = WAIT_RVALID;
            end
         end
         WAIT_RVALID: begin
            if (tmoHit || data_rvalid_i) stateNext = DONE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state        <= IDLE;
         weQ          <= 1'b0;
         sizeQ        <= '0;
         offQ         <= '0;
         tmoCnt       <= '0;
         data_we_o    <= 1'b0;
         data_be_o    <= '0;
         data_addr_o  <= '0;
         data_wdata_o <= '0;
         lsu_data_o   <= '0;
         lsu_err_o    <= 1'b0;
      end else begin
         state     <= stateNext;
         lsu_err_o <= 1'b0;
         case (state)
            IDLE: begin
               tmoCnt <= '0;
               if (lsu_req_i) begin
                  weQ          <= lsu_we_i;
                  sizeQ        <= lsu_size_i;
                  offQ         <= lsu_addr_i[1:0];
                  data_we_o    <= lsu_we_i;
                  data_be_o    <= beNext;
                  data_addr_o  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
                  data_wdata_o <= wdataNext;
                  if (misalign) begin
                     lsu_err_o  <= 1'b1;
                     lsu_data_o <= '0;
                  end
               end
            end
            WAIT_GNT, WAIT_RVALID: begin
               if (TIMEOUT != 0) tmoCnt <= tmoCnt + 1'b1;
               if (tmoHit) begin
                  lsu_err_o  <= 1'b1;
                  lsu_data_o <= '0;
               end else if ((state == WAIT_RVALID) && data_rvalid_i && !weQ) begin
                  lsu_data_o <= loadData;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
